// File: rtl/dm_blk_xfer.sv
// Block-copy bus initiator for the data memory: reads src..src+N-1 and writes dst..dst+N-1.
// Define DM_XFER_CSUM_EN to add the `csum` output (running sum of copied words).
module dm_blk_xfer #(
  parameter int DMA_SIZE = 3,
  parameter int DMD_SIZE = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [DMA_SIZE-1:0] src_add,
  input  logic [DMA_SIZE-1:0] dst_add,
  input  logic [DMA_SIZE:0]   xfer_cnt,
  output logic                busy,
  output logic                done,
  output logic                ps_dm_cslt,
  output logic                ps_dm_wrb,
  output logic [DMA_SIZE-1:0] dg_dm_add,
  output logic [DMD_SIZE-1:0] bc_dt,
  input  logic [DMD_SIZE-1:0] dm_bc_dt
`ifdef DM_XFER_CSUM_EN
  ,
  output logic [DMD_SIZE-1:0] csum
`endif
);

  typedef enum logic [2:0] {IDLE, RD_CMD, RD_CAP, WR_CMD, LAST} state_t;

  localparam logic [DMA_SIZE:0] MAX_CNT = {1'b1, {DMA_SIZE{1'b0}}};

  state_t                state;
  logic [DMA_SIZE-1:0]   src_ptr;
  logic [DMA_SIZE-1:0]   dst_ptr;
  logic [DMA_SIZE:0]     remaining;
  logic [DMD_SIZE-1:0]   hold;
  logic [DMA_SIZE:0]     cnt_sat;

  always_comb begin
    cnt_sat = xfer_cnt;
    if (xfer_cnt > MAX_CNT) cnt_sat = MAX_CNT;
  end

  // Outputs are set on the edge that enters a state, so each one is valid during that state.
  // bc_dt only moves on leaving WR_CMD: the memory rewrites its last write address every cycle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      ps_dm_cslt <= 1'b0;
      ps_dm_wrb  <= 1'b0;
      dg_dm_add  <= '0;
      bc_dt      <= '0;
      src_ptr    <= '0;
      dst_ptr    <= '0;
      remaining  <= '0;
      hold       <= '0;
`ifdef DM_XFER_CSUM_EN
      csum       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            src_ptr   <= src_add;
            dst_ptr   <= dst_add;
            remaining <= cnt_sat;
            busy      <= 1'b1;
`ifdef DM_XFER_CSUM_EN
            csum      <= '0;
`endif
            if (cnt_sat == '0) begin
              state <= LAST;
              done  <= 1'b1;
            end else begin
              state      <= RD_CMD;
              ps_dm_cslt <= 1'b1;
              ps_dm_wrb  <= 1'b0;
              dg_dm_add  <= src_add;
            end
          end
        end

        RD_CMD: begin
          state      <= RD_CAP;
          ps_dm_cslt <= 1'b0;
        end

        RD_CAP: begin
          hold       <= dm_bc_dt;
          state      <= WR_CMD;
          ps_dm_cslt <= 1'b1;
          ps_dm_wrb  <= 1'b1;
          dg_dm_add  <= dst_ptr;
        end

        WR_CMD: begin
          bc_dt     <= hold;
          src_ptr   <= src_ptr + DMA_SIZE'(1);
          dst_ptr   <= dst_ptr + DMA_SIZE'(1);
          remaining <= remaining - (DMA_SIZE+1)'(1);
          ps_dm_wrb <= 1'b0;
`ifdef DM_XFER_CSUM_EN
          csum      <= csum + hold;
`endif
          if (remaining != (DMA_SIZE+1)'(1)) begin
            state      <= RD_CMD;
            ps_dm_cslt <= 1'b1;
            dg_dm_add  <= src_ptr + DMA_SIZE'(1);
          end else begin
            state      <= LAST;
            ps_dm_cslt <= 1'b0;
            done       <= 1'b1;
          end
        end

        LAST: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_blk_xfer.sv
// Self-checking bench for dm_blk_xfer: directed table, corner sequences and random copies
// against a memmove-style reference model and a cycle-timing model.
module tb_dm_blk_xfer;

  localparam int AW    = 3;
  localparam int DW    = 4;
  localparam int DEPTH = 8;
  localparam int MAXC  = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] src_add = '0;
  logic [AW-1:0] dst_add = '0;
  logic [AW:0]   xfer_cnt = '0;
  logic          busy, done, ps_dm_cslt, ps_dm_wrb;
  logic [AW-1:0] dg_dm_add;
  logic [DW-1:0] bc_dt;
  logic [DW-1:0] dm_bc_dt = '0;
`ifdef DM_XFER_CSUM_EN
  logic [DW-1:0] csum;
`endif

  always #5 clk = ~clk;

  dm_blk_xfer #(.DMA_SIZE(AW), .DMD_SIZE(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .src_add    (src_add),
    .dst_add    (dst_add),
    .xfer_cnt   (xfer_cnt),
    .busy       (busy),
    .done       (done),
    .ps_dm_cslt (ps_dm_cslt),
    .ps_dm_wrb  (ps_dm_wrb),
    .dg_dm_add  (dg_dm_add),
    .bc_dt      (bc_dt),
    .dm_bc_dt   (dm_bc_dt)
`ifdef DM_XFER_CSUM_EN
    ,
    .csum       (csum)
`endif
  );

  // Data memory: registered read, write data one cycle after the command,
  // last write address rewritten with bc_dt on every edge.
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] ld_img [DEPTH];
  logic [DW-1:0] snap [DEPTH];
  logic          ld_req = 1'b0;
  logic [AW-1:0] last_wr = '0;
  logic          wr_valid = 1'b0;

  always @(posedge clk) begin
    if (ld_req) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= ld_img[i];
      wr_valid <= 1'b0;
    end else begin
      if (ps_dm_cslt && !ps_dm_wrb) dm_bc_dt <= mem[dg_dm_add];
      if (wr_valid) mem[last_wr] <= bc_dt;
      if (ps_dm_cslt && ps_dm_wrb) begin
        last_wr  <= dg_dm_add;
        wr_valid <= 1'b1;
      end
    end
  end

  int n_checks = 0;
  int n_err    = 0;

  logic          tr_cslt [MAXC+1];
  logic          tr_wrb  [MAXC+1];
  logic          tr_busy [MAXC+1];
  logic          tr_done [MAXC+1];
  logic [AW-1:0] tr_add  [MAXC+1];
  logic [DW-1:0] tr_bc   [MAXC+1];
`ifdef DM_XFER_CSUM_EN
  logic [DW-1:0] tr_csum [MAXC+1];
`endif

  typedef struct {
    int s;
    int d;
    int c;
    int restart_at;
    int exp_done;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_load();
    for (int i = 0; i < DEPTH; i++) snap[i] = ld_img[i];
    @(negedge clk);
    ld_req = 1'b1;
    @(negedge clk);
    ld_req = 1'b0;
  endtask

  task automatic rand_img();
    for (int i = 0; i < DEPTH; i++) ld_img[i] = DW'($urandom_range(0, (1 << DW) - 1));
  endtask

  // Start sampled at edge E0; cycle k of the trace is the cycle after edge E(k-1).
  task automatic run_xfer(input int s, input int d, input int c, input int restart_at,
                          input int rst_at);
    @(negedge clk);
    tr_bc[0] = bc_dt;
    tr_cslt[0] = ps_dm_cslt;
    tr_wrb[0] = ps_dm_wrb;
    src_add  = AW'(s);
    dst_add  = AW'(d);
    xfer_cnt = (AW+1)'(c);
    start    = 1'b1;
    for (int cyc = 1; cyc <= MAXC; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      rst   = 1'b0;
      if (cyc == restart_at) begin
        start    = 1'b1;
        src_add  = AW'(s + 3);
        dst_add  = AW'(d + 2);
        xfer_cnt = (AW+1)'(1);
      end
      if (cyc == rst_at) rst = 1'b1;
      tr_cslt[cyc] = ps_dm_cslt;
      tr_wrb[cyc]  = ps_dm_wrb;
      tr_busy[cyc] = busy;
      tr_done[cyc] = done;
      tr_add[cyc]  = dg_dm_add;
      tr_bc[cyc]   = bc_dt;
`ifdef DM_XFER_CSUM_EN
      tr_csum[cyc] = csum;
`endif
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  function automatic int first_done();
    for (int cyc = 1; cyc <= MAXC; cyc++) if (tr_done[cyc] === 1'b1) return cyc;
    return -1;
  endfunction

  function automatic int done_count();
    int n = 0;
    for (int cyc = 1; cyc <= MAXC; cyc++) if (tr_done[cyc] === 1'b1) n++;
    return n;
  endfunction

  // Reference: copy of the original image (reads always see pre-copy data), plus
  // the three-cycle-per-word bus timeline.
  task automatic verify(input string tag, input int s, input int d, input int c);
    int n;
    int e_cs, e_busy, e_done, e_add, e_stab, e_mem;
    logic [DW-1:0] exp_mem [DEPTH];
    logic [DW-1:0] sum;
    n = (c > DEPTH) ? DEPTH : c;
    e_cs = 0; e_busy = 0; e_done = 0; e_add = 0; e_stab = 0; e_mem = 0;
    sum = '0;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = snap[i];
    for (int k = 0; k < n; k++) begin
      exp_mem[(d + k) % DEPTH] = snap[(s + k) % DEPTH];
      sum = sum + snap[(s + k) % DEPTH];
    end
    for (int cyc = 1; cyc <= MAXC; cyc++) begin
      int  k, ph, ea;
      logic ecs;
      k   = (cyc - 1) / 3;
      ph  = (cyc - 1) % 3;
      ecs = (cyc <= 3 * n) && (ph != 1);
      if (tr_cslt[cyc] !== ecs) e_cs++;
      if (tr_busy[cyc] !== (cyc <= 3 * n + 1)) e_busy++;
      if (tr_done[cyc] !== (cyc == 3 * n + 1)) e_done++;
      if (ecs) begin
        ea = (ph == 0) ? (s + k) % DEPTH : (d + k) % DEPTH;
        if (tr_add[cyc] !== AW'(ea) || tr_wrb[cyc] !== (ph == 2)) e_add++;
      end
      if (tr_bc[cyc] !== tr_bc[cyc-1] && !(tr_cslt[cyc-1] === 1'b1 && tr_wrb[cyc-1] === 1'b1))
        e_stab++;
    end
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== exp_mem[i]) e_mem++;
    check({tag, " cslt_timeline_errs"}, 32'(e_cs), 0);
    check({tag, " busy_timeline_errs"}, 32'(e_busy), 0);
    check({tag, " done_timeline_errs"}, 32'(e_done), 0);
    check({tag, " addr_wrb_errs"}, 32'(e_add), 0);
    check({tag, " bc_dt_hold_errs"}, 32'(e_stab), 0);
    check({tag, " mem_word_errs"}, 32'(e_mem), 0);
`ifdef DM_XFER_CSUM_EN
    check({tag, " csum_at_done"}, 32'(tr_csum[3 * n + 1]), 32'(sum));
    check({tag, " csum_held"}, 32'(tr_csum[MAXC]), 32'(sum));
`else
    if (sum === 'x) $display("note: unknown data in %s", tag);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{s: 0, d: 4, c: 2,  restart_at: 0, exp_done: 7};
    tbl[1] = '{s: 6, d: 1, c: 3,  restart_at: 0, exp_done: 10};
    tbl[2] = '{s: 2, d: 5, c: 0,  restart_at: 0, exp_done: 1};
    tbl[3] = '{s: 3, d: 4, c: 12, restart_at: 0, exp_done: 25};
    tbl[4] = '{s: 0, d: 4, c: 2,  restart_at: 3, exp_done: 7};
    tbl[5] = '{s: 5, d: 6, c: 8,  restart_at: 0, exp_done: 25};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy), 0);
    check("reset done", 32'(done), 0);
    check("reset cslt", 32'(ps_dm_cslt), 0);
    check("reset wrb", 32'(ps_dm_wrb), 0);
    check("reset add", 32'(dg_dm_add), 0);
    check("reset bc_dt", 32'(bc_dt), 0);
`ifdef DM_XFER_CSUM_EN
    check("reset csum", 32'(csum), 0);
`endif
    rst = 1'b0;

    // Basic two-word copy
    for (int i = 0; i < DEPTH; i++) ld_img[i] = '0;
    ld_img[0] = 4'hA;
    ld_img[1] = 4'h5;
    do_load();
    run_xfer(0, 4, 2, 0, 0);
    check("basic mem4", 32'(mem[4]), 32'hA);
    check("basic mem5", 32'(mem[5]), 32'h5);
    check("basic cslt_pattern",
          32'({tr_cslt[1], tr_cslt[2], tr_cslt[3], tr_cslt[4], tr_cslt[5], tr_cslt[6], tr_cslt[7]}),
          32'b1011010);
    check("basic done_cycle", 32'(first_done()), 7);
    verify("basic", 0, 4, 2);

    // Address wrap
    rand_img();
    ld_img[6] = 4'h1;
    ld_img[7] = 4'h2;
    ld_img[0] = 4'h3;
    do_load();
    run_xfer(6, 1, 3, 0, 0);
    check("wrap mem1..3", 32'({mem[1], mem[2], mem[3]}), 32'h123);
    check("wrap read_seq", 32'({tr_add[1], tr_add[4], tr_add[7]}), 32'({3'd6, 3'd7, 3'd0}));
    verify("wrap", 6, 1, 3);

    // Directed table
    for (int v = 0; v < 6; v++) begin
      string tag;
      tag = $sformatf("tbl%0d", v);
      rand_img();
      do_load();
      run_xfer(tbl[v].s, tbl[v].d, tbl[v].c, tbl[v].restart_at, 0);
      check({tag, " done_cycle"}, 32'(first_done()), 32'(tbl[v].exp_done));
      check({tag, " done_count"}, 32'(done_count()), 1);
      verify(tag, tbl[v].s, tbl[v].d, tbl[v].c);
    end

    // Reset in the middle of a copy, then a clean re-issue
    for (int i = 0; i < DEPTH; i++) ld_img[i] = '0;
    ld_img[0] = 4'hA;
    ld_img[1] = 4'h5;
    do_load();
    run_xfer(0, 4, 2, 0, 4);
    check("rst busy_after", 32'(tr_busy[5]), 0);
    check("rst cslt_after", 32'(tr_cslt[5]), 0);
    check("rst bc_dt_after", 32'(tr_bc[5]), 0);
    check("rst no_done", 32'(done_count()), 0);
    run_xfer(0, 4, 2, 0, 0);
    check("reissue mem4", 32'(mem[4]), 32'hA);
    check("reissue mem5", 32'(mem[5]), 32'h5);
    check("reissue done_cycle", 32'(first_done()), 7);
    verify("reissue", 0, 4, 2);

    // Checksum words 3, F, 2
    for (int i = 0; i < DEPTH; i++) ld_img[i] = '0;
    ld_img[0] = 4'h3;
    ld_img[1] = 4'hF;
    ld_img[2] = 4'h2;
    do_load();
    run_xfer(0, 3, 3, 0, 0);
`ifdef DM_XFER_CSUM_EN
    check("csum value", 32'(tr_csum[10]), 32'h4);
`endif
    verify("csum", 0, 3, 3);

    // Random copies: disjoint ranges, or dst = src + 1
    for (int t = 0; t < 12; t++) begin
      int s, c, n, d;
      rand_img();
      do_load();
      s = $urandom_range(0, DEPTH - 1);
      c = $urandom_range(0, 2 * DEPTH - 1);
      n = (c > DEPTH) ? DEPTH : c;
      if (n <= DEPTH / 2 && $urandom_range(0, 1) == 1)
        d = (s + n + $urandom_range(0, DEPTH - 2 * n)) % DEPTH;
      else
        d = (s + 1) % DEPTH;
      run_xfer(s, d, c, 0, 0);
      check($sformatf("rnd%0d done_cycle", t), 32'(first_done()), 32'(3 * n + 1));
      verify($sformatf("rnd%0d", t), s, d, c);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
